// File: rtl/problema1_mem_arb_pkg.sv
// Shared types and defaults for the two-master arbiter in front of the
// single-port on-chip memory.
package problema1_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int MAX_BURST_DEFAULT = 4;

endpackage

// File: rtl/problema1_mem_arb_fsm.sv
// Ownership FSM: grants one master per cycle, keeps the current owner for up
// to MAX_BURST contended accesses, and breaks ties away from the last winner.
module problema1_mem_arb_fsm
  import problema1_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             win0, win1;

  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // last_q = 1 means m1 won most recently, so m0 takes a tie
        if (req0_i && (!req1_i || last_q)) win0 = 1'b1;
        else if (req1_i)                   win1 = 1'b1;
      end
      ST_OWN0: begin
        if (req0_i && (!req1_i || cnt_q != CNT_MAX)) win0 = 1'b1;
        else if (req1_i)                             win1 = 1'b1;
      end
      ST_OWN1: begin
        if (req1_i && (!req0_i || cnt_q != CNT_MAX)) win1 = 1'b1;
        else if (req0_i)                             win0 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (win0) begin
      if (state_q == ST_OWN0) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
        state_d = ST_OWN0;
        cnt_d   = CNT_ONE;
        last_d  = 1'b0;
      end
    end else if (win1) begin
      if (state_q == ST_OWN1) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      end else begin
        state_d = ST_OWN1;
        cnt_d   = CNT_ONE;
        last_d  = 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // No access may be issued while reset is held
  assign gnt0_o = win0 & ~reset_i;
  assign gnt1_o = win1 & ~reset_i;

endmodule

// File: rtl/problema1_memory_arbiter.sv
// Two-master Avalon-MM arbiter for the 1024x32 single-port memory: request
// muxing, waitrequest generation and per-master readdatavalid tracking.
module problema1_memory_arbiter
  import problema1_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0, req1;
  logic gnt0, gnt1;
  logic wr_sel;
  logic rvld0_q, rvld0_d;
  logic rvld1_q, rvld1_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  problema1_mem_arb_fsm #(
    .MAX_BURST(MAX_BURST)
  ) u_fsm (
    .clk_i  (clk),
    .reset_i(reset),
    .req0_i (req0),
    .req1_i (req1),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  // Issue stage: m0 drives the memory bus unless m1 holds the grant
  assign wr_sel         = gnt1 ? m1_write : m0_write;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = mem_chipselect & wr_sel;
  assign mem_address    = gnt1 ? m1_address : m0_address;
  assign mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
  assign mem_byteenable = wr_sel ? (gnt1 ? m1_byteenable : m0_byteenable) : '1;

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // A simultaneous write wins, so only a pure read produces return data
  assign rvld0_d = gnt0 & m0_read & ~m0_write;
  assign rvld1_d = gnt1 & m1_read & ~m1_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      rvld0_q <= 1'b0;
      rvld1_q <= 1'b0;
    end else begin
      rvld0_q <= rvld0_d;
      rvld1_q <= rvld1_d;
    end
  end

  // Return stage: memory data is valid one cycle after a read issue
  assign m0_readdatavalid = rvld0_q & ~reset;
  assign m1_readdatavalid = rvld1_q & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: doc/problema1_memory_arbiter.md
# problema1_memory_arbiter

Two-port Avalon-MM arbiter sharing the single-port 1024×32 on-chip memory of `problema1` between two requesters, typically the CPU data master (m0) and a custom DMA/accelerator master (m1). It sits between both masters and the memory's s1 port. It muxes address, data and byteenable into the memory, and stalls the losing master with `waitrequest`. It returns read data one cycle after issue with a per-master `readdatavalid`. Bounded-burst ownership plus round-robin tie-break guarantees neither master starves.

## Interface
Parameters:
- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byteenable width (DATA_W/8)
- `MAX_BURST`, 4, max consecutive accesses granted to one master while the other is requesting (≥1)

Ports (x ∈ {0,1}):
- `clk`  in  1  single clock for all logic
- `reset`  in  1  synchronous, active-high reset
- `mx_address`  in  ADDR_W  word address from master x
- `mx_byteenable`  in  BE_W  byte lanes for writes
- `mx_read`  in  1  read request
- `mx_write`  in  1  write request
- `mx_writedata`  in  DATA_W  write data
- `mx_waitrequest`  out  1  high = request not accepted this cycle
- `mx_readdata`  out  DATA_W  equals `mem_readdata`, meaningful only with `mx_readdatavalid`
- `mx_readdatavalid`  out  1  one-cycle pulse, read data valid
- `mem_address`  out  ADDR_W  to memory
- `mem_byteenable`  out  BE_W  to memory; all-ones on reads
- `mem_chipselect`  out  1  access issued this cycle
- `mem_write`  out  1  issued access is a write
- `mem_writedata`  out  DATA_W  to memory
- `mem_readdata`  in  DATA_W  memory output, valid the cycle after a read is issued

## Operation
- Request: `req_x = mx_read | mx_write`. If both are high, write wins and the read is ignored; the bench flags this as illegal.
- FSM states: IDLE, OWN0, OWN1. Registers: `last` (1 bit), `cnt` (saturating at MAX_BURST).
- IDLE: serve the sole requester. On a tie, serve the master ≠ `last`. Next state OWN_winner, `cnt`=1, `last`=winner. With no request, stay in IDLE.
- OWNx, x requesting, and (other idle or `cnt` < MAX_BURST): serve x, `cnt`++.
- OWNx, other requesting, and (x idle or `cnt` = MAX_BURST): serve the other. Next state OWN_other, `cnt`=1, `last`=other.
- OWNx, nobody requesting: go to IDLE, `cnt`=0.
- Served master: `waitrequest`=0. The other master: `waitrequest`=1 while it requests. With no request, `waitrequest`=1 as well.
- Exactly one access is issued per cycle at most. `mem_chipselect`=1 iff a master is served. The mem_* signals are muxed from the served master; when nobody is served they hold m0 values, which is don't-care with chipselect=0.
- A served read sets `rv_x` (registered) → `mx_readdatavalid`=1 next cycle.

## Timing
- Grant is combinational from the requests and the registered FSM; the access is accepted in the same cycle. Best case latency: 0 wait cycles.
- Write completes in the accepted cycle.
- Read data arrives exactly 1 cycle after acceptance. Back-to-back reads give one valid per cycle.
- `readdatavalid` for m0 and m1 are never high in the same cycle.
- Worst-case wait for a requesting master is MAX_BURST cycles.
- Reset (sync) values: state IDLE, `last`=1 (m0 wins first tie), `cnt`=0, both `readdatavalid`=0.
- During reset, both `waitrequest`=1 and `mem_chipselect`=0, `mem_write`=0.
- Reset mid-read: the pending `readdatavalid` is dropped; no pulse after reset.
- Simultaneous release by the owner and request by the other: switch in the same cycle, no bubble.
- `cnt` never exceeds MAX_BURST. With MAX_BURST=1 the arbiter alternates every cycle under contention.

## Structure
- Package `problema1_mem_arb_pkg`: state enum (IDLE/OWN0/OWN1) and the default MAX_BURST constant.
- Sub-module `problema1_mem_arb_fsm`: state, `cnt`, `last` and grant outputs (`gnt0`, `gnt1`).
- The top level holds the datapath muxes and the `readdatavalid` registers.

## Test plan
- m0 reads address 0x005 (mem preloaded 0xDEADBEEF), m1 idle → m0_waitrequest=0 cycle 0; m0_readdatavalid=1 with 0xDEADBEEF on cycle 1.
- Both masters request from IDLE after reset → m0 served first, m1_waitrequest=1 that cycle, m1 served the next cycle.
- Both stream reads continuously, MAX_BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0…; no master waits more than 4 cycles.
- m1 writes 0x12345678 with byteenable=4'b0010 to 0x3FF, then reads it back → mem_byteenable=0010 on the write; read returns the old word with byte 1 replaced by 0x56.
- Reset asserted the cycle after an m0 read is accepted → m0_readdatavalid stays 0; both waitrequest=1 and mem_chipselect=0 during reset.
- Owner m0 stops and m1 starts in the same cycle → m1 served that cycle, state OWN1, no idle cycle.
